// File: rtl/multicycle_controller_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle RV32I control unit:
//   - FSM state enumeration
//   - datapath select encodings (AluOp, ImmSrc, AluSrcA/B, ResultSrc,
//     RegDataSel)
//   - RV32I opcode and Funct3 constants used by the decoders
//   - helper telling which branch Funct3 values the core implements
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_JALR    = 4'd11,
        S_LINK    = 4'd12,
        S_LUI     = 4'd13,
        S_HALT    = 4'd14
    } ctrlStateT;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } aluOpT;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } immSrcT;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'd0,
        SRCA_OLDPC = 2'd1,
        SRCA_REGA  = 2'd2,
        SRCA_ZERO  = 2'd3
    } aluSrcAT;

    typedef enum logic [1:0] {
        SRCB_REGB = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2,
        SRCB_ZERO = 2'd3
    } aluSrcBT;

    typedef enum logic [1:0] {
        RES_ALUOUTREG = 2'd0,
        RES_MDR       = 2'd1,
        RES_ALUOUT    = 2'd2
    } resultSrcT;

    typedef enum logic [1:0] {
        RD_RESULT    = 2'd0,
        RD_ALUOUTREG = 2'd1,
        RD_IMM       = 2'd2,
        RD_SIGNBIT   = 2'd3
    } regDataSelT;

    // Major opcodes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Branch Funct3
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    // ALU Funct3 (R-type and I-type share these)
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    // True for the branch Funct3 values handled by the BRANCH state.
    function automatic logic isBranchF3Supported(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundle between the control unit and the datapath.
//   Datapath -> control : Opcode, Funct3, Funct7b5 (IR fields), Zero, SignBit
//   Control -> datapath : PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, ImmSrc,
//                         AluOp, AluSrcA, AluSrcB, ResultSrc, RegDataSel,
//                         Retire, Illegal
// master = control unit side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multicycle_controller_if;

    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       Zero;
    logic       SignBit;

    logic       PcEn;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IrWrite;
    logic       RegWrite;
    logic [2:0] ImmSrc;
    logic [2:0] AluOp;
    logic [1:0] AluSrcA;
    logic [1:0] AluSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] RegDataSel;
    logic       Retire;
    logic       Illegal;

    modport master (
        input  Opcode, Funct3, Funct7b5, Zero, SignBit,
        output PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, ImmSrc, AluOp,
               AluSrcA, AluSrcB, ResultSrc, RegDataSel, Retire, Illegal
    );

    modport slave (
        output Opcode, Funct3, Funct7b5, Zero, SignBit,
        input  PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, ImmSrc, AluOp,
               AluSrcA, AluSrcB, ResultSrc, RegDataSel, Retire, Illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode for R-type and I-type arithmetic.
//   opcode   in  7  IR[6:0]
//   funct3   in  3  IR[14:12]
//   funct7b5 in  1  IR[30]; only meaningful for R-type add/sub
//   aluOp    out 3  ALU operation
//   isSlt    out 1  instruction is slt/slti (writeback takes the sign bit)
// Anything that is not an R/I arithmetic op decodes to ADD with isSlt=0, so
// jal/jalr link writebacks never pick up the slt path.
// ---------------------------------------------------------------------------
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output aluOpT      aluOp,
    output logic       isSlt
);

    logic isRType;
    logic isAluOp;

    assign isRType = (opcode == OP_RTYPE);
    assign isAluOp = isRType || (opcode == OP_ITYPE);

    always_comb begin
        aluOp = ALU_ADD;
        isSlt = 1'b0;
        if (isAluOp) begin
            case (funct3)
                // Funct7b5 selects sub only for R-type; addi ignores it.
                F3_ADD:  aluOp = (isRType && funct7b5) ? ALU_SUB : ALU_ADD;
                F3_SLT: begin
                    aluOp = ALU_SUB;
                    isSlt = 1'b1;
                end
                F3_XOR:  aluOp = ALU_XOR;
                F3_OR:   aluOp = ALU_OR;
                F3_AND:  aluOp = ALU_AND;
                default: aluOp = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore-style control FSM for the multicycle RV32I core. Walks each
// instruction through fetch/decode/execute/memory/writeback and drives every
// datapath enable and mux select.
//   clk  in  core clock, rising edge
//   rst  in  asynchronous, active-low reset
//   bus  master side of multicycle_controller_if (IR fields and ALU flags in,
//        datapath controls, Retire and Illegal out)
// Outputs are decoded from the current state (plus IR fields and the live
// Zero/SignBit for branches). They are also gated by rst so that nothing is
// enabled while reset is held, yet FETCH controls appear immediately after
// release and the very first clock edge performs the fetch.
// ---------------------------------------------------------------------------
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    ctrlStateT  stateReg;

    aluOpT      decAluOp;
    logic       decIsSlt;

    logic       pcEn;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    immSrcT     immSrc;
    aluOpT      aluOp;
    aluSrcAT    aluSrcA;
    aluSrcBT    aluSrcB;
    resultSrcT  resultSrc;
    regDataSelT regDataSel;
    logic       retire;
    logic       illegal;
    logic       branchTaken;

    alu_decoder u_alu_decoder (
        .opcode   (bus.Opcode),
        .funct3   (bus.Funct3),
        .funct7b5 (bus.Funct7b5),
        .aluOp    (decAluOp),
        .isSlt    (decIsSlt)
    );

    // ------------------------------------------------------------------
    // State register and next-state logic. IR is written at the end of
    // FETCH, so from DECODE onward the IR fields are stable for the whole
    // instruction and can steer later transitions as well.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= S_FETCH;
        end else begin
            case (stateReg)
                S_FETCH:  stateReg <= S_DECODE;
                S_DECODE: begin
                    case (bus.Opcode)
                        OP_LOAD, OP_STORE: stateReg <= S_MEMADR;
                        OP_RTYPE:          stateReg <= S_EXECR;
                        OP_ITYPE:          stateReg <= S_EXECI;
                        OP_BRANCH:         stateReg <= isBranchF3Supported(bus.Funct3)
                                                       ? S_BRANCH : S_HALT;
                        OP_JAL:            stateReg <= S_JAL;
                        OP_JALR:           stateReg <= S_JALR;
                        OP_LUI:            stateReg <= S_LUI;
                        default:           stateReg <= S_HALT;
                    endcase
                end
                S_MEMADR:  stateReg <= (bus.Opcode == OP_STORE) ? S_MEMWR : S_MEMREAD;
                S_MEMREAD: stateReg <= S_MEMWB;
                S_MEMWB:   stateReg <= S_FETCH;
                S_MEMWR:   stateReg <= S_FETCH;
                S_EXECR:   stateReg <= S_ALUWB;
                S_EXECI:   stateReg <= S_ALUWB;
                S_ALUWB:   stateReg <= S_FETCH;
                S_BRANCH:  stateReg <= S_FETCH;
                S_JAL:     stateReg <= S_ALUWB;
                S_JALR:    stateReg <= S_LINK;
                S_LINK:    stateReg <= S_ALUWB;
                S_LUI:     stateReg <= S_FETCH;
                S_HALT:    stateReg <= S_HALT;
                default:   stateReg <= S_FETCH;
            endcase
        end
    end

    // Branch condition from the live ALU flags of the RegA - RegB compare.
    always_comb begin
        case (bus.Funct3)
            F3_BEQ:  branchTaken = bus.Zero;
            F3_BNE:  branchTaken = !bus.Zero;
            F3_BLT:  branchTaken = bus.SignBit;
            F3_BGE:  branchTaken = !bus.SignBit;
            default: branchTaken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        pcEn       = 1'b0;
        adrSrc     = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regWrite   = 1'b0;
        immSrc     = IMM_I;
        aluOp      = ALU_ADD;
        aluSrcA    = SRCA_PC;
        aluSrcB    = SRCB_REGB;
        resultSrc  = RES_ALUOUTREG;
        regDataSel = RD_RESULT;
        retire     = 1'b0;
        illegal    = 1'b0;

        if (rst) begin
            case (stateReg)
                S_FETCH: begin
                    irWrite   = 1'b1;
                    pcEn      = 1'b1;
                    aluSrcA   = SRCA_PC;
                    aluSrcB   = SRCB_FOUR;
                    resultSrc = RES_ALUOUT;
                end
                // Precompute the branch/jal target into AluOutReg.
                S_DECODE: begin
                    aluSrcA = SRCA_OLDPC;
                    aluSrcB = SRCB_IMM;
                    immSrc  = (bus.Opcode == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEMADR: begin
                    aluSrcA = SRCA_REGA;
                    aluSrcB = SRCB_IMM;
                    immSrc  = (bus.Opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    adrSrc    = 1'b1;
                    resultSrc = RES_ALUOUTREG;
                end
                S_MEMWB: begin
                    resultSrc  = RES_MDR;
                    regDataSel = RD_RESULT;
                    regWrite   = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMWR: begin
                    adrSrc    = 1'b1;
                    resultSrc = RES_ALUOUTREG;
                    memWrite  = 1'b1;
                    retire    = 1'b1;
                end
                S_EXECR: begin
                    aluSrcA = SRCA_REGA;
                    aluSrcB = SRCB_REGB;
                    aluOp   = decAluOp;
                end
                S_EXECI: begin
                    aluSrcA = SRCA_REGA;
                    aluSrcB = SRCB_IMM;
                    immSrc  = IMM_I;
                    aluOp   = decAluOp;
                end
                // Shared writeback for ALU ops and for the jal/jalr link value.
                S_ALUWB: begin
                    regWrite   = 1'b1;
                    regDataSel = decIsSlt ? RD_SIGNBIT : RD_ALUOUTREG;
                    retire     = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA   = SRCA_REGA;
                    aluSrcB   = SRCB_REGB;
                    aluOp     = ALU_SUB;
                    resultSrc = RES_ALUOUTREG;
                    pcEn      = branchTaken;
                    retire    = 1'b1;
                end
                // PC <- target held in AluOutReg; ALU forms OldPC+4 for the link.
                S_JAL: begin
                    resultSrc = RES_ALUOUTREG;
                    pcEn      = 1'b1;
                    aluSrcA   = SRCA_OLDPC;
                    aluSrcB   = SRCB_FOUR;
                end
                S_JALR: begin
                    aluSrcA   = SRCA_REGA;
                    aluSrcB   = SRCB_IMM;
                    immSrc    = IMM_I;
                    resultSrc = RES_ALUOUT;
                    pcEn      = 1'b1;
                end
                S_LINK: begin
                    aluSrcA = SRCA_OLDPC;
                    aluSrcB = SRCB_FOUR;
                end
                S_LUI: begin
                    immSrc     = IMM_U;
                    regDataSel = RD_IMM;
                    regWrite   = 1'b1;
                    retire     = 1'b1;
                end
                S_HALT: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

    assign bus.PcEn       = pcEn;
    assign bus.AdrSrc     = adrSrc;
    assign bus.MemWrite   = memWrite;
    assign bus.IrWrite    = irWrite;
    assign bus.RegWrite   = regWrite;
    assign bus.ImmSrc     = immSrc;
    assign bus.AluOp      = aluOp;
    assign bus.AluSrcA    = aluSrcA;
    assign bus.AluSrcB    = aluSrcB;
    assign bus.ResultSrc  = resultSrc;
    assign bus.RegDataSel = regDataSel;
    assign bus.Retire     = retire;
    assign bus.Illegal    = illegal;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core. A Moore-style FSM steps each instruction through fetch, decode, execute, memory and writeback. It drives every enable and mux select of the datapath, and consumes the datapath's instruction-register fields plus its `Zero`/`SignBit` flags. It sits directly upstream of the datapath; the two are wired together one-to-one in the core top.

## Interface

Parameters: none.

- `clk`  in  1  core clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `Opcode`  in  7  IR[6:0]
- `Funct3`  in  3  IR[14:12]
- `Funct7b5`  in  1  IR[30]
- `Zero`  in  1  ALU result == 0 (combinational, current cycle)
- `SignBit`  in  1  ALU result bit 31 (combinational, current cycle)
- `PcEn`, `AdrSrc`, `MemWrite`, `IrWrite`, `RegWrite`  out  1 each  datapath enables/select
- `ImmSrc`  out  3  immediate format: I=0, S=1, B=2, J=3, U=4
- `AluOp`  out  3  ADD=0, SUB=1, AND=2, OR=3, XOR=4
- `AluSrcA`  out  2  PC=0, OldPC=1, RegA=2, zero=3
- `AluSrcB`  out  2  RegB=0, Imm=1, const 4=2, zero=3
- `ResultSrc`  out  2  AluOutReg=0, MDR=1, AluOut=2
- `RegDataSel`  out  2  Result=0, AluOutReg=1, Imm=2, SignBitReg=3
- `Retire`  out  1  one-cycle pulse in the final state of each instruction
- `Illegal`  out  1  sticky; unsupported opcode was decoded

## Operation

Supported instructions:
- R-type: add, sub, and, or, xor, slt
- I-type: addi, andi, ori, xori, slti
- lw, sw
- beq, bne, blt, bge
- jal, jalr, lui

Any other opcode, or a branch with an unsupported `Funct3`, enters HALT.

States and outputs. Signals not listed are 0; `AluOp` defaults to ADD.
- FETCH: AdrSrc=0, IrWrite=1, AluSrcA=PC, AluSrcB=4, ResultSrc=AluOut, PcEn=1. Next: DECODE.
- DECODE: AluSrcA=OldPC, AluSrcB=Imm, ImmSrc=J if jal else B. This leaves the branch/jal target in AluOutReg. Next state by opcode: MEMADR (lw/sw), EXECR, EXECI, BRANCH, JAL, JALR, LUI, or HALT.
- MEMADR: AluSrcA=RegA, AluSrcB=Imm, ImmSrc=S for sw else I. Next: MEMREAD (lw) or MEMWR (sw).
- MEMREAD: AdrSrc=1, ResultSrc=AluOutReg. Next: MEMWB.
- MEMWB: ResultSrc=MDR, RegDataSel=Result, RegWrite=1, Retire=1. Next: FETCH.
- MEMWR: AdrSrc=1, ResultSrc=AluOutReg, MemWrite=1, Retire=1. Next: FETCH.
- EXECR: AluSrcA=RegA, AluSrcB=RegB, AluOp from the ALU decoder. Next: ALUWB.
- EXECI: AluSrcA=RegA, AluSrcB=Imm, ImmSrc=I, AluOp from the ALU decoder. Next: ALUWB.
- ALUWB: RegWrite=1, RegDataSel=SignBitReg for slt/slti else AluOutReg, Retire=1. Next: FETCH.
- BRANCH: AluSrcA=RegA, AluSrcB=RegB, AluOp=SUB, ResultSrc=AluOutReg. PcEn follows the branch condition:
  - beq: `Zero`
  - bne: `!Zero`
  - blt: `SignBit`
  - bge: `!SignBit`
  - Retire=1. Next: FETCH.
- JAL: ResultSrc=AluOutReg, PcEn=1, AluSrcA=OldPC, AluSrcB=4. Next: ALUWB, which writes the link value OldPC+4.
- JALR: AluSrcA=RegA, AluSrcB=Imm, ImmSrc=I, ResultSrc=AluOut, PcEn=1. Target bit 0 is not cleared. Next: LINK.
- LINK: AluSrcA=OldPC, AluSrcB=4. Next: ALUWB.
- LUI: ImmSrc=U, RegDataSel=Imm, RegWrite=1, Retire=1. Next: FETCH.
- HALT: all enables 0, Illegal=1. Stays in HALT until reset.

ALU decoder:
- add/addi: ADD
- sub (R-type with Funct7b5=1): SUB
- slt/slti: SUB, with RegDataSel=SignBitReg at writeback
- and/andi: AND
- or/ori: OR
- xor/xori: XOR
- `Funct7b5` is ignored for I-type.

## Timing

Instruction latency in cycles, counted from the FETCH edge:

| Instruction | Cycles |
|---|---|
| lui, branch | 3 |
| R-type, I-type, sw, jal | 4 |
| lw, jalr | 5 |

Reset:
- While `rst`=0: state=FETCH, `Illegal`=0, and PcEn, IrWrite, MemWrite, RegWrite and Retire are forced to 0. All selects are 0.
- The first rising edge after `rst` deasserts executes FETCH.
- Reset asserted in any state, including mid-instruction or HALT, aborts immediately with no partial write.

Output timing:
- Outputs are a pure function of state, IR fields and the current `Zero`/`SignBit`.
- The branch `PcEn` is combinational on `Zero`/`SignBit` within the BRANCH cycle.
- Exactly one `Retire` pulse occurs per completed instruction; none in HALT.

## Structure

- Package `ctrl_pkg` holds:
  - the state enum
  - the AluOp, ImmSrc, AluSrcA/B, ResultSrc and RegDataSel encodings
  - opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111)
  - the branch `Funct3` constants
- Sub-module `alu_decoder` is combinational. It maps Opcode/Funct3/Funct7b5 to `AluOp` plus an `IsSlt` flag.
- The FSM state register, next-state logic and output logic live in the top module.

## Test plan

- Reset: hold `rst`=0 for 3 cycles → all enables 0 and `Illegal`=0. After release, cycle 1 shows IrWrite=1, PcEn=1, AluSrcB=2.
- `add` (Opcode 0110011, Funct3 0, Funct7b5 0) → states FETCH, DECODE, EXECR (AluOp=0), ALUWB (RegWrite=1, RegDataSel=1, Retire=1), then FETCH. `sub` gives AluOp=1.
- `lw` → 5 cycles; MEMREAD has AdrSrc=1; MEMWB has ResultSrc=1 and RegWrite=1. `sw` → 4 cycles, with MemWrite=1 only in MEMWR.
- `beq` with Zero=1 → PcEn=1 in BRANCH. `bne` with Zero=1 → PcEn=0. `blt` with SignBit=1 → PcEn=1. `bge` with SignBit=1 → PcEn=0. All take 3 cycles.
- `jal` → DECODE ImmSrc=3, JAL PcEn=1, then ALUWB RegDataSel=1. `jalr` → 5 cycles, LINK state present. `slti` → ALUWB RegDataSel=3.
- Opcode 1111111 → HALT: `Illegal`=1 and enables stay 0 for 10 cycles. Asserting `rst`=0 clears `Illegal` and restarts at FETCH.
